// File: rtl/id_ex_stage_reg_pkg.sv
// Shared types for the ID/EX pipeline register and its neighbours.
// The EX control bundle, ALU opcodes, forwarding selects and the x0 constant
// live here so the decoder, forwarding unit and EX muxes all agree on them.
package id_ex_stage_reg_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_PASS = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        FW_NONE     = 2'd0,
        FW_MEM_DATA = 2'd1,
        FW_WB_DATA  = 2'd2
    } fw_sel_e;

    typedef struct packed {
        logic    RegWrite;
        logic    MemRead;
        logic    MemWrite;
        logic    MemtoReg;
        logic    ALUSrc;
        logic    Branch;
        logic    Jump;
        alu_op_e alu_op;
    } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detector.sv
// Combinational load-use hazard detector.
// Flags when the instruction in EX is a load whose destination (other than x0)
// is read by the instruction currently in ID.
module load_use_detector
    import id_ex_stage_reg_pkg::*;
(
    input  logic       valid_EX,
    input  logic       mem_read_EX,
    input  logic [4:0] rd_addr_EX,
    input  logic       valid_ID,
    input  logic       uses_rs1_ID,
    input  logic [4:0] rs1_addr_ID,
    input  logic       uses_rs2_ID,
    input  logic [4:0] rs2_addr_ID,
    output logic       load_use
);

    logic rs1_match;
    logic rs2_match;

    // Compare each operand that the decoder says is actually read against the load's rd.
    always_comb begin
        rs1_match = uses_rs1_ID && (rs1_addr_ID == rd_addr_EX);
        rs2_match = uses_rs2_ID && (rs2_addr_ID == rd_addr_EX);
        load_use  = valid_EX && mem_read_EX && (rd_addr_EX != REG_ZERO) &&
                    valid_ID && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with integrated load-use hazard detection.
// Inserts a single bubble on load-use, squashes on an EX flush and freezes
// completely while the global hold is asserted.
// Optional build macro: ID_EX_PERF_EN adds bubble_cnt / flush_cnt counters.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_i,
    input  logic            flush_EX,
    input  logic            valid_ID,
    input  logic [XLEN-1:0] pc_ID,
    input  logic [4:0]      rs1_addr_ID,
    input  logic [4:0]      rs2_addr_ID,
    input  logic [4:0]      rd_addr_ID,
    input  logic            uses_rs1_ID,
    input  logic            uses_rs2_ID,
    input  logic [XLEN-1:0] rs1_data_ID,
    input  logic [XLEN-1:0] rs2_data_ID,
    input  logic [XLEN-1:0] imm_ID,
    input  id_ex_ctrl_t     ctrl_ID,
    output logic            stall_IF,
    output logic            stall_ID,
    output logic            valid_EX,
    output logic [XLEN-1:0] pc_EX,
    output logic [XLEN-1:0] rs1_data_EX,
    output logic [XLEN-1:0] rs2_data_EX,
    output logic [XLEN-1:0] imm_EX,
    output logic [4:0]      rs1_addr_EX,
    output logic [4:0]      rs2_addr_EX,
    output logic [4:0]      rd_addr_EX,
    output id_ex_ctrl_t     ctrl_EX
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]     bubble_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    logic load_use;

    load_use_detector u_load_use_detector (
        .valid_EX    (valid_EX),
        .mem_read_EX (ctrl_EX.MemRead),
        .rd_addr_EX  (rd_addr_EX),
        .valid_ID    (valid_ID),
        .uses_rs1_ID (uses_rs1_ID),
        .rs1_addr_ID (rs1_addr_ID),
        .uses_rs2_ID (uses_rs2_ID),
        .rs2_addr_ID (rs2_addr_ID),
        .load_use    (load_use)
    );

    // A flush kills the consumer anyway and a hold freezes everything globally, so neither stalls front-end.
    always_comb begin
        stall_IF = load_use && !flush_EX && !hold_i;
        stall_ID = stall_IF;
    end

    // Pipeline register: hold beats flush beats load-use bubble beats normal advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_EX    <= 1'b0;
            ctrl_EX     <= '0;
            pc_EX       <= RESET_PC;
            rs1_data_EX <= '0;
            rs2_data_EX <= '0;
            imm_EX      <= '0;
            rs1_addr_EX <= REG_ZERO;
            rs2_addr_EX <= REG_ZERO;
            rd_addr_EX  <= REG_ZERO;
        end else if (hold_i) begin
            valid_EX    <= valid_EX;
        end else if (flush_EX || load_use) begin
            valid_EX    <= 1'b0;
            ctrl_EX     <= '0;
            pc_EX       <= RESET_PC;
            rs1_data_EX <= '0;
            rs2_data_EX <= '0;
            imm_EX      <= '0;
            rs1_addr_EX <= REG_ZERO;
            rs2_addr_EX <= REG_ZERO;
            rd_addr_EX  <= REG_ZERO;
        end else begin
            valid_EX    <= valid_ID;
            ctrl_EX     <= valid_ID ? ctrl_ID : '0;
            pc_EX       <= pc_ID;
            rs1_data_EX <= rs1_data_ID;
            rs2_data_EX <= rs2_data_ID;
            imm_EX      <= imm_ID;
            rs1_addr_EX <= rs1_addr_ID;
            rs2_addr_EX <= rs2_addr_ID;
            rd_addr_EX  <= rd_addr_ID;
        end
    end

`ifdef ID_EX_PERF_EN
    // Count inserted bubbles by cause; a flush takes credit when both apply, nothing counts while frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (!hold_i) begin
            if (flush_EX) begin
                flush_cnt <= flush_cnt + 32'd1;
            end else if (load_use) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register with integrated load-use hazard detection.
- Captures decoded operands, addresses and control from ID.
- Drives rs1_addr_EX/rs2_addr_EX/rd_addr_EX and the EX control bundle that the forwarding unit and EX muxes consume.
- Inserts one-cycle bubbles on load-use, squashes on branch flush, freezes on global hold.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, pc_EX value on reset/bubble.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- hold_i  in  1  global freeze (memory wait); ID/EX retains contents.
- flush_EX  in  1  taken branch/jump resolved in EX; squash ID instruction.
- valid_ID  in  1  ID holds a real instruction.
- pc_ID  in  XLEN  PC of ID instruction.
- rs1_addr_ID, rs2_addr_ID, rd_addr_ID  in  5 each  register addresses.
- uses_rs1_ID, uses_rs2_ID  in  1 each  decoder says operand is read.
- rs1_data_ID, rs2_data_ID  in  XLEN each  register file read data.
- imm_ID  in  XLEN  sign-extended immediate.
- ctrl_ID  in  id_ex_ctrl_t  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump, alu_op}.
- stall_IF  out  1  hold PC.
- stall_ID  out  1  hold IF/ID register.
- valid_EX  out  1  EX holds a real instruction.
- pc_EX, rs1_data_EX, rs2_data_EX, imm_EX  out  XLEN each  registered.
- rs1_addr_EX, rs2_addr_EX, rd_addr_EX  out  5 each  registered.
- ctrl_EX  out  id_ex_ctrl_t  registered control.

Behaviour:
- Reset (async, rst=1):
  - valid_EX=0, ctrl_EX=all zero, pc_EX=RESET_PC.
  - All data outputs and addresses = 0.
  - stall_IF=stall_ID=0.
- Hazard, combinational:
  - load_use = valid_EX & ctrl_EX.MemRead & (rd_addr_EX!=0) & valid_ID & ((uses_rs1_ID & rs1_addr_ID==rd_addr_EX) | (uses_rs2_ID & rs2_addr_ID==rd_addr_EX)).
  - stall_IF = stall_ID = load_use & ~flush_EX & ~hold_i.
  - hold_i alone does not drive stall_*; the hold is distributed globally.
- Register update at posedge clk, priority order:
  1. hold_i=1: all outputs keep their values. flush_EX is ignored; the branch remains in EX and reasserts flush_EX after the hold.
  2. flush_EX=1: bubble.
  3. load_use=1: bubble.
  4. Otherwise: all outputs load from ID; valid_EX<=valid_ID; ctrl_EX<=valid_ID ? ctrl_ID : '0.
- Bubble definition:
  - valid_EX<=0, ctrl_EX<='0.
  - rd_addr_EX, rs1_addr_EX, rs2_addr_EX <= 0, so no spurious forward or hazard match.
  - Data fields: don't-care; implementation zeroes them.
- Latency:
  - One cycle ID->EX.
  - Load-use costs exactly one bubble. The next cycle the load is in MEM, hazard clears, and the consumer later receives FW_WB_DATA.
- Back-to-back loads to the same rd each produce an independent single bubble.
- A load with rd=x0 never stalls.
- Reset mid-stall: outputs return to reset values immediately; stall_* drop because valid_EX=0.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined:
  - Adds outputs bubble_cnt and flush_cnt, each 32-bit.
  - Counters are async-reset to 0 and wrap at 2^32.
  - Each increments once per clock edge in which a load-use or flush bubble is inserted, and never while hold_i=1.
  - Flush wins over load-use for counting.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package defines holds:
  - id_ex_ctrl_t packed struct.
  - alu_op_e.
  - fw_sel_e, shared with the forwarding unit.
  - Constant REG_ZERO=5'd0.
- One natural sub-module: load_use_detector, purely combinational, producing load_use. Instantiate it once; the register logic stays in id_ex_stage_reg.

Test Plan:
- Straight-line: ID add x3,x1,x2 with valid_ID=1 -> next cycle valid_EX=1, rd_addr_EX=3, ctrl_EX=ctrl_ID, stall_*=0.
- Load-use rs1: EX lw x5 (MemRead=1, rd=5); ID add x6,x5,x7 (uses_rs1=1).
  - Same cycle: stall_IF=stall_ID=1.
  - Next cycle: valid_EX=0, ctrl_EX=0.
  - Following cycle: ID add enters EX with rs1_addr_EX=5, stall_*=0.
- No false stall:
  - EX lw x5; ID lui x5 (uses_rs1=uses_rs2=0) -> stall=0.
  - EX lw x0; ID add x1,x0,x0 -> stall=0.
- Flush vs load-use: EX lw x5 with flush_EX=1; ID uses x5 -> stall_*=0, next cycle bubble. With ID_EX_PERF_EN: flush_cnt +1, bubble_cnt unchanged.
- Hold: hold_i=1 for 3 cycles with flush_EX=1 and new ID data -> all EX outputs unchanged for 3 cycles; after release, flush bubble inserted.
- Async reset: assert rst mid-cycle during a load-use stall -> outputs zero / pc_EX=RESET_PC immediately, without waiting for clk; stall_*=0.
